// File: rtl/sha256_digest_match_pkg.sv
// Shared types and helpers for the digest-match consumer sitting behind the SHA-256 transform.
package sha256_digest_match_pkg;

    typedef logic [255:0] digest_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } match_state_t;

    localparam int MATCH_DEPTH_DEFAULT = 4;
    localparam int IDX_W_DEFAULT       = 32;

    typedef struct packed {
        digest_t                  target;
        logic [IDX_W_DEFAULT-1:0] count;
    } match_job_t;

    // True when the top 'bits' bits of a and b agree; lower bits are don't-care.
    function automatic logic digest_msb_eq(digest_t a, digest_t b, int unsigned bits);
        digest_t mask;
        mask = ~({256{1'b1}} >> bits);
        return ((a ^ b) & mask) == '0;
    endfunction

endpackage

// File: rtl/sha256_digest_match_if.sv
// Job configuration, digest stream and match report signals of the digest matcher.
interface sha256_digest_match_if
    import sha256_digest_match_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT
) ();
    logic             cfg_rdy;
    logic             cfg_vld;
    digest_t          cfg_target;
    logic [IDX_W-1:0] cfg_count;
    logic             abort;
    logic             hash_rdy;
    logic             hash_vld;
    digest_t          hash;
    logic             match_rdy;
    logic             match_vld;
    logic [IDX_W-1:0] match_idx;
    logic [15:0]      match_total;
    logic             busy;
    logic             done;

    modport slave (
        output cfg_rdy, hash_rdy, match_vld, match_idx, match_total, busy, done,
        input  cfg_vld, cfg_target, cfg_count, abort, hash_vld, hash, match_rdy
    );

    modport master (
        input  cfg_rdy, hash_rdy, match_vld, match_idx, match_total, busy, done,
        output cfg_vld, cfg_target, cfg_count, abort, hash_vld, hash, match_rdy
    );
endinterface

// File: rtl/sha256_digest_match_fifo.sv
// Small synchronous FIFO holding matched stream indices; head is valid whenever not empty.
module match_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the address bits coincide.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/sha256_digest_match.sv
// Compares each SHA-256 digest against a target, counts checked digests and queues matching indices.
module sha256_digest_match
    import sha256_digest_match_pkg::*;
#(
    parameter int DIGEST_BITS = 256,
    parameter int MATCH_DEPTH = MATCH_DEPTH_DEFAULT,
    parameter int IDX_W       = IDX_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    sha256_digest_match_if.slave  bus
);
    match_state_t     state_reg;
    match_state_t     state_next;
    digest_t          target_reg;
    logic [IDX_W-1:0] limit_reg;
    logic [IDX_W-1:0] index_reg;
    logic [15:0]      total_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] fifo_head;

    logic hash_rdy;
    logic abort_hit;
    logic cfg_acc;
    logic beat;
    logic is_match;
    logic last_beat;

    // Registered-only ready: no combinational path from hash_vld back to hash_rdy.
    assign hash_rdy  = (state_reg == RUN) && !fifo_full;
    assign abort_hit = bus.abort && (state_reg != IDLE);
    assign cfg_acc   = (state_reg == IDLE) && bus.cfg_vld;
    assign beat      = bus.hash_vld && hash_rdy && !bus.abort;
    assign is_match  = digest_msb_eq(bus.hash, target_reg, DIGEST_BITS);
    assign last_beat = beat && (index_reg == limit_reg - IDX_W'(1));

    match_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MATCH_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (beat && is_match),
        .push_data (index_reg),
        .pop       (bus.match_rdy),
        .flush     (abort_hit),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_comb begin
        state_next = state_reg;
        if (abort_hit) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.cfg_vld) state_next = (bus.cfg_count == '0) ? DRAIN : RUN;
                RUN:     if (last_beat)   state_next = DRAIN;
                DRAIN:   if (fifo_empty)  state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            limit_reg  <= '0;
            index_reg  <= '0;
            total_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (cfg_acc) begin
                target_reg <= bus.cfg_target;
                limit_reg  <= bus.cfg_count;
                index_reg  <= '0;
                total_reg  <= '0;
            end else if (beat) begin
                index_reg <= index_reg + IDX_W'(1);
                if (is_match && (total_reg != 16'hFFFF)) total_reg <= total_reg + 16'd1;
            end
        end
    end

    // Gating the head keeps match_idx at zero whenever nothing is queued.
    assign bus.cfg_rdy     = (state_reg == IDLE);
    assign bus.hash_rdy    = hash_rdy;
    assign bus.match_vld   = !fifo_empty;
    assign bus.match_idx   = fifo_empty ? '0 : fifo_head;
    assign bus.match_total = total_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
endmodule
